dpram_be: RTL and testbench
===========================

Name: dpram_be

Overview:
- Parametrised successor to the single-clock dual-port RAM used for ZX81 video/program memory.
- Two independent read/write ports on one clock, with:
  - per-byte write enables
  - selectable read-during-write mode
  - configurable read latency
  - same-address collision detection and arbitration
  - out-of-range address protection
- Sits between the CPU/ULA address decode and the display fetch path, in place of the plain 8-bit RAM.

Parameters:
- DATAWIDTH, 8, word width in bits; must be a multiple of 8.
- ADDRWIDTH, 14, address width.
- NUMWORDS, 12288, implemented words; must be at most 2**ADDRWIDTH.
- READ_LATENCY, 1, cycles from sampled address to q; legal values 1 or 2.
- RDW_MODE, 0, same-port read-during-write result: 0 = new (merged) data, 1 = old data.

Ports:
- clock, in, 1: single system clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high.
- clocken_a, in, 1: port A enable; when low, port A is ignored and its pipeline holds.
- wren_a, in, 1: port A write.
- byteen_a, in, DATAWIDTH/8: port A byte enables; bit i covers data[8i+7:8i].
- address_a, in, ADDRWIDTH: port A address.
- data_a, in, DATAWIDTH: port A write data.
- q_a, out, DATAWIDTH: port A read data.
- clocken_b, wren_b, byteen_b, address_b, data_b, q_b: identical set for port B.
- collision, out, 1: one-cycle pulse flagging a same-address write conflict.
- busy, out, 1: clear engine active; tied 0 when the optional feature is absent.

Behaviour:
- Reset:
  - q_a, q_b, collision and all pipeline registers go to 0 on the first clock edge with reset high.
  - Memory contents are retained unless DPRAM_CLEAR_EN is defined.
  - Port operations presented in the same cycle as reset are discarded, writes included.
- Access:
  - A port acts when clocken_x=1 and reset=0.
  - A write updates only the bytes whose byteen bit is 1. wren=1 with byteen=0 is a read.
  - Every enabled access is also a read.
  - Read data appears on q_x READ_LATENCY cycles after the sampling edge.
- Latency 2: an extra output register, advanced only when clocken_x=1. q_x holds its value between enabled cycles.
- Same-port read-during-write:
  - RDW_MODE=0: q returns the merged word, i.e. new bytes where enabled, old bytes elsewhere.
  - RDW_MODE=1: q returns the pre-write word.
- Cross-port, same address, one port writes while the other only reads: the reader gets old data in both modes.
- Both ports write the same address in the same cycle:
  - Bytes enabled on A take data_a.
  - Bytes enabled only on B take data_b.
  - collision=1 on the following cycle for exactly one cycle, only if at least one byte overlaps.
  - Each port's own q follows the RDW rule applied to the final stored word.
- Out of range (address >= NUMWORDS):
  - The write is dropped, and it takes no part in collision checks.
  - The read returns 0 with normal latency.
- Reset mid-operation: in-flight reads are lost and q returns to 0. No partial write ever lands.

Optional Feature:
- Macro: DPRAM_CLEAR_EN.
- Defined:
  - Two-state FSM, IDLE and CLEAR.
  - Reset deassertion enters CLEAR. A counter walks addresses 0..NUMWORDS-1, one word per clock, writing 0.
  - busy=1 throughout CLEAR. Both ports are ignored: no writes, q held at 0, no collision.
  - After the write to NUMWORDS-1, the FSM goes to IDLE and busy drops on the next cycle. A full clear takes NUMWORDS cycles.
  - Reset during CLEAR restarts the walk from 0.
- Not defined: busy tied 0, contents retained across reset, no counter logic.

Test Plan:
- DATAWIDTH=16, READ_LATENCY=1: write A 0x1234 to addr 5 with byteen=11, then read B addr 5 -> q_b=0x1234 one cycle after the read edge.
- Byte merge: addr 5 holds 0x1234; write A data 0xABCD, byteen=01 -> addr 5 becomes 0x12CD. RDW_MODE=0 gives q_a=0x12CD; RDW_MODE=1 gives q_a=0x1234.
- Collision: same cycle, A writes 0x1111 with byteen=01 and B writes 0x2222 with byteen=11 to addr 9 -> stored 0x2211, collision pulses once. Repeat with disjoint bytes (A=01, B=10) -> stored 0x2211 again, collision stays 0.
- READ_LATENCY=2: read addr 5 with clocken_a 1,0,1 -> q_a updates only after two enabled edges. Address 12300 with NUMWORDS=12288 -> write dropped, read returns 0.
- Reset pulse during a pending read -> q_a=q_b=0 next cycle. Memory at addr 5 is unchanged (feature off).
- DPRAM_CLEAR_EN, NUMWORDS=16: release reset -> busy high for exactly 16 cycles and all words read 0. A port write attempted while busy is discarded. Reset at cycle 8 restarts the walk, giving busy for a further 16 cycles.

Source files
------------

// File: rtl/dpram_be.sv
// Single-clock dual-port RAM with per-byte write enables, same-address collision flag
// and 1/2-cycle read latency. Define DPRAM_CLEAR_EN to add a post-reset clear engine.
module dpram_be #(
  parameter int unsigned DATAWIDTH    = 8,
  parameter int unsigned ADDRWIDTH    = 14,
  parameter int unsigned NUMWORDS     = 12288,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RDW_MODE     = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clocken_a,
  input  logic                   wren_a,
  input  logic [DATAWIDTH/8-1:0] byteen_a,
  input  logic [ADDRWIDTH-1:0]   address_a,
  input  logic [DATAWIDTH-1:0]   data_a,
  output logic [DATAWIDTH-1:0]   q_a,
  input  logic                   clocken_b,
  input  logic                   wren_b,
  input  logic [DATAWIDTH/8-1:0] byteen_b,
  input  logic [ADDRWIDTH-1:0]   address_b,
  input  logic [DATAWIDTH-1:0]   data_b,
  output logic [DATAWIDTH-1:0]   q_b,
  output logic                   collision,
  output logic                   busy
);
  localparam int unsigned NB = DATAWIDTH / 8;
  localparam int unsigned IW = (NUMWORDS > 1) ? $clog2(NUMWORDS) : 1;
  localparam logic [ADDRWIDTH:0] LIMIT = (ADDRWIDTH + 1)'(NUMWORDS);
  localparam bit RDW_OLD = (RDW_MODE != 0);

  logic [DATAWIDTH-1:0] mem [NUMWORDS];

  logic                 clearing;
  logic                 act_a, act_b, in_a, in_b, we_a, we_b, same;
  logic [IW-1:0]        idx_a, idx_b;
  logic [DATAWIDTH-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;
  logic [DATAWIDTH-1:0] q1_a, q1_b, q2_a, q2_b;

  // Port A bytes win over port B bytes; unselected bytes keep the stored value.
  function automatic logic [DATAWIDTH-1:0] merge(
    input logic [DATAWIDTH-1:0] base,
    input logic [DATAWIDTH-1:0] da,
    input logic [NB-1:0]        ea,
    input logic [DATAWIDTH-1:0] db,
    input logic [NB-1:0]        eb
  );
    logic [DATAWIDTH-1:0] res;
    res = base;
    for (int unsigned i = 0; i < NB; i++) begin
      if (ea[i])      res[8*i +: 8] = da[8*i +: 8];
      else if (eb[i]) res[8*i +: 8] = db[8*i +: 8];
    end
    return res;
  endfunction

  assign act_a = clocken_a && !reset && !clearing;
  assign act_b = clocken_b && !reset && !clearing;
  assign in_a  = {1'b0, address_a} < LIMIT;
  assign in_b  = {1'b0, address_b} < LIMIT;
  assign idx_a = address_a[IW-1:0];
  assign idx_b = address_b[IW-1:0];
  assign we_a  = act_a && wren_a && in_a && (|byteen_a);
  assign we_b  = act_b && wren_b && in_b && (|byteen_b);
  assign same  = (address_a == address_b);

  assign old_a = in_a ? mem[idx_a] : '0;
  assign old_b = in_b ? mem[idx_b] : '0;

  // Each side computes the full final word, so a dual write to one address stores identically from both.
  assign new_a = merge(old_a, data_a, we_a ? byteen_a : '0,
                       data_b, (we_b && same) ? byteen_b : '0);
  assign new_b = merge(old_b, data_a, (we_a && same) ? byteen_a : '0,
                       data_b, we_b ? byteen_b : '0);

  assign rd_a = !in_a ? '0 : (we_a && !RDW_OLD) ? new_a : old_a;
  assign rd_b = !in_b ? '0 : (we_b && !RDW_OLD) ? new_b : old_b;

`ifdef DPRAM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [IW-1:0] LAST = IW'(NUMWORDS - 1);

  state_t        state, state_next;
  logic [IW-1:0] clr_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_addr <= clr_addr + IW'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_addr == LAST) state_next = IDLE;
  end

  assign clearing = (state == CLEAR);
  assign busy     = clearing;
`else
  assign clearing = 1'b0;
  assign busy     = 1'b0;
`endif

  always_ff @(posedge clock) begin
`ifdef DPRAM_CLEAR_EN
    if (clearing && !reset) mem[clr_addr] <= '0;
`endif
    if (we_a) mem[idx_a] <= new_a;
    if (we_b) mem[idx_b] <= new_b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q1_a      <= '0;
      q1_b      <= '0;
      q2_a      <= '0;
      q2_b      <= '0;
      collision <= 1'b0;
    end else begin
      if (act_a) q1_a <= rd_a;
      if (act_b) q1_b <= rd_b;
      if (clocken_a && !clearing) q2_a <= q1_a;
      if (clocken_b && !clearing) q2_b <= q1_b;
      collision <= we_a && we_b && same && (|(byteen_a & byteen_b));
    end
  end

  assign q_a = (READ_LATENCY == 2) ? q2_a : q1_a;
  assign q_b = (READ_LATENCY == 2) ? q2_b : q1_b;

endmodule

// File: tb/tb_dpram_be.sv
// Scoreboard bench for dpram_be: four instances cover both read latencies and both RDW modes.
module tb_dpram_be;
`ifdef DPRAM_CLEAR_EN
  localparam int NW = 16;
`else
  localparam int NW = 12288;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clocken_a, wren_a, clocken_b, wren_b;
  logic [1:0]  byteen_a, byteen_b;
  logic [13:0] address_a, address_b;
  logic [15:0] data_a, data_b;
  logic [15:0] q_a [4];
  logic [15:0] q_b [4];
  logic        collision [4];
  logic        busy [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dpram_be #(
      .DATAWIDTH(16), .ADDRWIDTH(14), .NUMWORDS(NW),
      .READ_LATENCY(1 + g / 2), .RDW_MODE(g % 2)
    ) dut (
      .clock(clk), .reset(reset),
      .clocken_a(clocken_a), .wren_a(wren_a), .byteen_a(byteen_a),
      .address_a(address_a), .data_a(data_a), .q_a(q_a[g]),
      .clocken_b(clocken_b), .wren_b(wren_b), .byteen_b(byteen_b),
      .address_b(address_b), .data_b(data_b), .q_b(q_b[g]),
      .collision(collision[g]), .busy(busy[g])
    );
  end

  typedef struct packed {
    logic        rst, acc_a, acc_b, coll, busy;
    logic [15:0] new_a, old_a, new_b, old_b;
  } rec_t;

  rec_t        sbq [$];
  logic [15:0] mm [NW];
  int          clear_left = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [15:0] put(input logic [15:0] w, input logic [15:0] d,
                                      input logic [1:0] be);
    logic [15:0] res;
    res = w;
    if (be[0]) res[7:0]  = d[7:0];
    if (be[1]) res[15:8] = d[15:8];
    return res;
  endfunction

  // Reference model: applies one clock edge of port activity and queues the expected outcome.
  task automatic drive(input int rst, input int cea, input int wea, input int bea, input int ada,
                       input int da, input int ceb, input int web, input int beb, input int adb,
                       input int db);
    rec_t r;
    bit   ina, inb, wa, wb;
    r = '0;
    reset = (rst != 0);
    clocken_a = (cea != 0); wren_a = (wea != 0); byteen_a = 2'(bea);
    address_a = 14'(ada);   data_a = 16'(da);
    clocken_b = (ceb != 0); wren_b = (web != 0); byteen_b = 2'(beb);
    address_b = 14'(adb);   data_b = 16'(db);
    if (rst != 0) begin
      r.rst = 1'b1;
`ifdef DPRAM_CLEAR_EN
      for (int i = 0; i < NW; i++) mm[i] = '0;
      clear_left = NW;
`endif
      r.busy = (clear_left > 0);
    end else if (clear_left > 0) begin
      clear_left--;
      r.busy = (clear_left > 0);
    end else begin
      ina = (ada < NW);
      inb = (adb < NW);
      wa  = (cea != 0) && (wea != 0) && ina && (bea != 0);
      wb  = (ceb != 0) && (web != 0) && inb && (beb != 0);
      r.acc_a = (cea != 0);
      r.acc_b = (ceb != 0);
      r.old_a = ina ? mm[ada] : '0;
      r.old_b = inb ? mm[adb] : '0;
      if (wb) mm[adb] = put(mm[adb], 16'(db), 2'(beb));
      if (wa) mm[ada] = put(mm[ada], 16'(da), 2'(bea));
      r.new_a = !ina ? '0 : wa ? mm[ada] : r.old_a;
      r.new_b = !inb ? '0 : wb ? mm[adb] : r.old_b;
      r.coll  = wa && wb && (ada == adb) && ((bea & beb) != 0);
    end
    sbq.push_back(r);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int rst);
    drive(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_a(input int ad, input int d, input int be);
    drive(0, 1, 1, be, ad, d, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_a(input int ad);
    drive(0, 1, 0, 0, ad, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_b(input int ad);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, ad, 0);
  endtask

  function automatic int pick_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 6)  return s;
    if (s == 6) return NW - 1;
    if (s == 7) return NW;
    if (s == 8) return NW + 12;
    return $urandom_range(0, 16383);
  endfunction

  task automatic check(input string nm, input int g, input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, g, $time, act, exp);
    end
  endtask

  // Monitor: one record per edge; expected q is the Lth most recent accepted read.
  initial begin
    rec_t        r;
    logic [15:0] la [2];
    logic [15:0] pa [2];
    logic [15:0] lb [2];
    logic [15:0] pb [2];
    for (int i = 0; i < 2; i++) begin la[i] = '0; pa[i] = '0; lb[i] = '0; pb[i] = '0; end
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue expected a record", $time);
      end else begin
        r = sbq.pop_front();
        if (r.rst) begin
          for (int i = 0; i < 2; i++) begin la[i] = '0; pa[i] = '0; lb[i] = '0; pb[i] = '0; end
        end else begin
          if (r.acc_a) begin pa = la; la[0] = r.new_a; la[1] = r.old_a; end
          if (r.acc_b) begin pb = lb; lb[0] = r.new_b; lb[1] = r.old_b; end
        end
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
          check("q_a", g, q_a[g], (g / 2 == 1) ? pa[g % 2] : la[g % 2]);
          check("q_b", g, q_b[g], (g / 2 == 1) ? pb[g % 2] : lb[g % 2]);
          check("collision", g, 16'(collision[g]), 16'(r.coll));
          check("busy", g, 16'(busy[g]), 16'(r.busy));
        end
      end
    end
  end

  initial begin
    idle(1);
    idle(1);
    repeat (7) idle(0);
    idle(1);
    wr_a(3, 16'h5A5A, 3);
    while (clear_left > 0) idle(0);
    idle(0);
    rd_b(3);
    for (int i = 0; i < NW; i += 2) drive(0, 1, 1, 3, i, 0, 1, 1, 3, i + 1, 0);

    wr_a(5, 16'h1234, 3);
    rd_b(5);
    idle(0);
    wr_a(5, 16'hABCD, 1);
    rd_a(5);
    drive(0, 1, 1, 1, 9, 16'h1111, 1, 1, 3, 9, 16'h2222);
    rd_a(9);
    idle(0);
    drive(0, 1, 1, 1, 9, 16'h1111, 1, 1, 2, 9, 16'h2222);
    rd_b(9);
    drive(0, 1, 0, 0, 9, 0, 1, 1, 3, 9, 16'h7777);
    rd_a(5);
    drive(0, 0, 1, 3, 6, 16'hDEAD, 0, 0, 0, 0, 0);
    rd_a(9);
    idle(0);
    wr_a(NW + 12, 16'hFFFF, 3);
    rd_a(NW + 12);
    drive(0, 1, 1, 3, NW + 12, 16'h1, 1, 1, 3, NW + 12, 16'h2);
    drive(0, 1, 0, 0, 5, 0, 1, 0, 0, 9, 0);
    idle(1);
    rd_a(5);
    idle(0);

    for (int k = 0; k < 800; k++) begin
      drive($urandom_range(0, 59) == 0 ? 1 : 0,
            $urandom_range(0, 3) != 0 ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 3),
            pick_addr(), $urandom_range(0, 65535),
            $urandom_range(0, 3) != 0 ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 3),
            pick_addr(), $urandom_range(0, 65535));
    end
    repeat (3) idle(0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
